// File: rtl/stream_demux2_pkg.sv
// stream_demux2_pkg: shared state type and default widths for the 1-to-2 stream demux.
package stream_demux2_pkg;
   typedef enum logic [1:0] {IDLE, ROUTE0, ROUTE1} demux_state_t;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 2;
   localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: small synchronous FIFO holding one output port's beats, head presented combinationally.
module stream_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_data
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LIM = DEPTH[AW:0];
   localparam logic [AW:0] C_ONE = 1;
   localparam logic [AW-1:0] P_ONE = 1;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [AW:0] r_cnt;
   logic w_push, w_pop;
   assign o_full  = (r_cnt == LIM);
   assign o_empty = (r_cnt == '0);
   assign o_data  = r_mem[r_rd];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr] <= i_data;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + P_ONE;
         if (w_pop) r_rd <= r_rd + P_ONE;
         if (w_push & ~w_pop) r_cnt <= r_cnt + C_ONE;
         else if (~w_push & w_pop) r_cnt <= r_cnt - C_ONE;
      end
endmodule

// File: rtl/stream_demux2.sv
// stream_demux2: routes whole packets from one valid/ready stream to one of two FIFO-buffered ports.
// Per-port packet counters are built only when STREAM_DEMUX2_STATS_EN is defined.
module stream_demux2 import stream_demux2_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             in_sel,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_last,
   output logic [CNT_W-1:0] out0_pkt_cnt,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_last,
   output logic [CNT_W-1:0] out1_pkt_cnt
);
   demux_state_t r_state;
   logic w_tgt, w_acc, w_full0, w_full1, w_empty0, w_empty1;
   logic [WIDTH:0] w_head0, w_head1;
   // the route is only open in IDLE; mid-packet the locked port wins
   assign w_tgt    = (r_state == IDLE) ? in_sel : (r_state == ROUTE1);
   assign in_ready = w_tgt ? ~w_full1 : ~w_full0;
   assign w_acc    = in_valid & in_ready;
   stream_fifo #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH)) u_fifo0 (
      .clk(clk), .reset(reset),
      .i_push(w_acc & ~w_tgt), .i_data({in_data, in_last}), .i_pop(out0_ready),
      .o_full(w_full0), .o_empty(w_empty0), .o_data(w_head0)
   );
   stream_fifo #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH)) u_fifo1 (
      .clk(clk), .reset(reset),
      .i_push(w_acc & w_tgt), .i_data({in_data, in_last}), .i_pop(out1_ready),
      .o_full(w_full1), .o_empty(w_empty1), .o_data(w_head1)
   );
   assign out0_valid = ~w_empty0;
   assign out0_data  = w_head0[WIDTH:1];
   assign out0_last  = out0_valid & w_head0[0];
   assign out1_valid = ~w_empty1;
   assign out1_data  = w_head1[WIDTH:1];
   assign out1_last  = out1_valid & w_head1[0];
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= IDLE;
      else if (w_acc) r_state <= in_last ? IDLE : (r_state == IDLE) ? (in_sel ? ROUTE1 : ROUTE0) : r_state;
`ifdef STREAM_DEMUX2_STATS_EN
   localparam logic [CNT_W-1:0] C_ONE = 1;
   logic [CNT_W-1:0] r_cnt0, r_cnt1;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (w_acc & in_last) begin
         if (w_tgt) r_cnt1 <= r_cnt1 + C_ONE;
         else r_cnt0 <= r_cnt0 + C_ONE;
      end
   assign out0_pkt_cnt = r_cnt0;
   assign out1_pkt_cnt = r_cnt1;
`else
   assign out0_pkt_cnt = '0;
   assign out1_pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_stream_demux2.sv
// tb_stream_demux2: directed bench for stream_demux2 with hand-computed expectations.
module tb_stream_demux2;
   logic clk = 1'b0, reset;
   logic in_valid, in_ready, in_last, in_sel;
   logic [7:0] in_data, out0_data, out1_data;
   logic out0_valid, out0_ready, out0_last, out1_valid, out1_ready, out1_last;
   logic [1:0] out0_pkt_cnt, out1_pkt_cnt;
   int n_checks = 0, n_errors = 0;

   always #5 clk = ~clk;

   stream_demux2 #(.WIDTH(8), .DEPTH(2), .CNT_W(2)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .in_sel(in_sel),
      .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data), .out0_last(out0_last),
      .out0_pkt_cnt(out0_pkt_cnt),
      .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data), .out1_last(out1_last),
      .out1_pkt_cnt(out1_pkt_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic l);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
      in_last  = l;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ce(input int v);
`ifdef STREAM_DEMUX2_STATS_EN
      return 32'(v % 4);
`else
      return 32'(0 * v);
`endif
   endfunction

   initial begin
      reset = 1'b0;
      drive(0, 0, 8'h00, 0);
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      tick();
      tick();
      chk("rst_v0", out0_valid, 0);
      chk("rst_v1", out1_valid, 0);
      chk("rst_l0", out0_last, 0);
      chk("rst_l1", out1_last, 0);
      chk("rst_c0", out0_pkt_cnt, 0);
      chk("rst_c1", out1_pkt_cnt, 0);
      chk("rst_rdy", in_ready, 1);
      reset = 1'b1;
      tick();
      // single beat to port 0
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      drive(1, 0, 8'hA5, 1);
      #1 chk("t1_rdy", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("t1_v0", out0_valid, 1);
      chk("t1_d0", out0_data, 8'hA5);
      chk("t1_l0", out0_last, 1);
      chk("t1_v1", out1_valid, 0);
      tick();
      chk("t1_gone", out0_valid, 0);
      chk("t1_l0z", out0_last, 0);
      // route lock: in_sel changes mid-packet are ignored
      drive(1, 1, 8'h11, 0);
      tick();
      chk("t2_v1a", out1_valid, 1);
      chk("t2_d1a", out1_data, 8'h11);
      chk("t2_l1a", out1_last, 0);
      chk("t2_v0a", out0_valid, 0);
      drive(1, 0, 8'h22, 0);
      #1 chk("t2_rdy", in_ready, 1);
      tick();
      chk("t2_d1b", out1_data, 8'h22);
      chk("t2_l1b", out1_last, 0);
      chk("t2_v0b", out0_valid, 0);
      drive(1, 0, 8'h33, 1);
      tick();
      in_valid = 1'b0;
      chk("t2_d1c", out1_data, 8'h33);
      chk("t2_l1c", out1_last, 1);
      chk("t2_v0c", out0_valid, 0);
      tick();
      chk("t2_done", out1_valid, 0);
      // backpressure on port 0
      out0_ready = 1'b0;
      drive(1, 0, 8'h01, 0);
      #1 chk("t3_rdy1", in_ready, 1);
      tick();
      drive(1, 0, 8'h02, 0);
      #1 chk("t3_rdy2", in_ready, 1);
      tick();
      drive(1, 0, 8'h03, 1);
      #1 chk("t3_full", in_ready, 0);
      chk("t3_head1", out0_data, 8'h01);
      tick();
      chk("t3_hold", in_ready, 0);
      out0_ready = 1'b1;
      #1 chk("t3_fullpop", in_ready, 0);
      tick();
      chk("t3_rdy3", in_ready, 1);
      chk("t3_head2", out0_data, 8'h02);
      tick();
      in_valid = 1'b0;
      chk("t3_head3", out0_data, 8'h03);
      chk("t3_last3", out0_last, 1);
      tick();
      chk("t3_drain", out0_valid, 0);
      // port independence while port 0 is stalled and full
      out0_ready = 1'b0;
      drive(1, 0, 8'hB1, 0);
      tick();
      drive(1, 0, 8'hB2, 1);
      tick();
      drive(1, 1, 8'h5A, 1);
      #1 chk("t4_rdy", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("t4_v1", out1_valid, 1);
      chk("t4_d1", out1_data, 8'h5A);
      chk("t4_l1", out1_last, 1);
      chk("t4_v0", out0_valid, 1);
      chk("t4_d0", out0_data, 8'hB1);
      tick();
      chk("t4_v1z", out1_valid, 0);
      chk("t4_stall", out0_data, 8'hB1);
      chk("t4_c0", out0_pkt_cnt, ce(3));
      chk("t4_c1", out1_pkt_cnt, ce(2));
      out0_ready = 1'b1;
      tick();
      chk("t4_d0b", out0_data, 8'hB2);
      chk("t4_l0b", out0_last, 1);
      tick();
      chk("t4_drain", out0_valid, 0);
      // asynchronous reset mid-packet
      out0_ready = 1'b0;
      drive(1, 0, 8'hC1, 0);
      tick();
      drive(1, 0, 8'hC2, 0);
      tick();
      drive(1, 0, 8'hC3, 0);
      #2 reset = 1'b0;
      #1 chk("t5_v0", out0_valid, 0);
      chk("t5_v1", out1_valid, 0);
      chk("t5_l0", out0_last, 0);
      chk("t5_c0", out0_pkt_cnt, 0);
      chk("t5_c1", out1_pkt_cnt, 0);
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      out1_ready = 1'b1;
      drive(1, 1, 8'h77, 1);
      #1 chk("t5_rdy", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("t5_v1b", out1_valid, 1);
      chk("t5_d1b", out1_data, 8'h77);
      chk("t5_v0b", out0_valid, 0);
      chk("t5_c1b", out1_pkt_cnt, ce(1));
      tick();
      // packet counters, including wrap at CNT_W=2
      out0_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 8'(i + 16), 1);
         tick();
         chk($sformatf("t6_c0_%0d", i), out0_pkt_cnt, ce(i + 1));
         chk($sformatf("t6_d0_%0d", i), out0_data, 32'(i + 16));
      end
      in_valid = 1'b0;
      chk("t6_c1", out1_pkt_cnt, ce(1));
      tick();
      chk("t6_drain", out0_valid, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
